// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the APB registers.
// Synchronises done_flag, captures {error,data} into a FWFT FIFO, tracks fill/irq/overrun/error count.
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rx_done_i,
  input  logic [7:0]    rx_data_i,
  input  logic [2:0]    rx_error_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rx_thresh_i,
  input  logic          overrun_clr_i,
  output logic [10:0]   rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          rx_irq_o,
  output logic          overrun_o,
  output logic [7:0]    err_count_o
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [1:0]    sync_q;
  logic          done_prev_q;
  logic          wr_pulse_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          irq_q, irq_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [10:0]   mem_q [DEPTH];

  logic          empty, full, do_rd, do_wr, drop;
  logic [AW-1:0] thresh_eff;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DEPTH_CNT);
    do_rd      = rd_en_i & ~empty;
    // A full FIFO still accepts a write when the head is popped on the same edge.
    do_wr      = wr_pulse_q & (~full | do_rd);
    drop       = wr_pulse_q & full & ~do_rd;
    wr_ptr_d   = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
    thresh_eff = (rx_thresh_i == '0) ? AW'(1) : rx_thresh_i;
    irq_d      = (count_q >= {1'b0, thresh_eff});
    overrun_d  = drop ? 1'b1 : (overrun_clr_i ? 1'b0 : overrun_q);
    err_count_d = err_count_q;
    if (wr_pulse_q && (|rx_error_i) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      done_prev_q <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx_done_i};
      done_prev_q <= sync_q[1];
      wr_pulse_q  <= sync_q[1] & ~done_prev_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  // Receiver holds data/error stable while done is asserted, so they are sampled unsynchronised.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= {rx_error_i, rx_data_i};
  end

  assign rd_data_o   = empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count_q;
  assign rx_irq_o    = irq_q;
  assign overrun_o   = overrun_q;
  assign err_count_o = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven and randomised self-checking bench for uart_rx_fifo.
// Expected values come from hand tables and a queue-based reference model.
`default_nettype none

module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [2:0]    rx_error = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rx_thresh = AW'(1);
  logic          overrun_clr = 1'b0;
  logic [10:0]   rd_data;
  logic          empty, full, rx_irq, overrun;
  logic [AW:0]   count;
  logic [7:0]    err_count;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .rx_done_i(rx_done), .rx_data_i(rx_data),
    .rx_error_i(rx_error), .rd_en_i(rd_en), .rx_thresh_i(rx_thresh),
    .overrun_clr_i(overrun_clr), .rd_data_o(rd_data), .empty_o(empty), .full_o(full),
    .count_o(count), .rx_irq_o(rx_irq), .overrun_o(overrun), .err_count_o(err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue plus the flag state.
  logic [10:0] mq[$];
  bit          ovr_m = 0;
  int          errc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit irq_for(input int size);
    int th;
    th = (rx_thresh == 0) ? 1 : int'(rx_thresh);
    return size >= th;
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("err_count", 32'(err_count), 32'(errc_m));
    chk("rx_irq", 32'(rx_irq), 32'(irq_for(mq.size())));
  endtask

  // One frame: done high for two clocks, optional rd_en/overrun_clr aligned to the write edge.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input bit rd_at, input bit clr_at);
    bit old_irq;
    bit rd_eff, full_b;
    @(negedge clock);
    rx_data = d; rx_error = e; rx_done = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rx_done = 1'b0;
    @(negedge clock);
    chk("pre_write_count", 32'(count), 32'(mq.size()));
    old_irq = irq_for(mq.size());
    rd_en = rd_at; overrun_clr = clr_at;
    @(negedge clock);
    rd_en = 1'b0; overrun_clr = 1'b0;
    rd_eff = rd_at && (mq.size() > 0);
    full_b = (mq.size() == DEPTH);
    if (rd_eff) void'(mq.pop_front());
    if (!full_b || rd_eff) mq.push_back({e, d});
    if (full_b && !rd_eff) ovr_m = 1;
    else if (clr_at) ovr_m = 0;
    if ((e != 0) && (errc_m < 255)) errc_m++;
    chk("write_count", 32'(count), 32'(mq.size()));
    chk("irq_lag_write", 32'(rx_irq), 32'(old_irq));
    @(negedge clock);
    check_all();
  endtask

  task automatic do_read();
    bit old_irq;
    @(negedge clock);
    old_irq = irq_for(mq.size());
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    chk("read_count", 32'(count), 32'(mq.size()));
    chk("read_head", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk("irq_lag_read", 32'(rx_irq), 32'(old_irq));
    @(negedge clock);
    check_all();
  endtask

  task automatic do_clear();
    @(negedge clock);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    ovr_m = 0;
    check_all();
  endtask

  typedef struct {
    int          op;      // 0 = frame, 1 = read
    logic [7:0]  d;
    logic [2:0]  e;
    int          exp_count;
    logic [10:0] exp_rd;
    int          exp_errc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit seen;
    logic [10:0] last_head;

    tbl[0] = '{0, 8'hA5, 3'b000, 1, 11'h0A5, 0};
    tbl[1] = '{1, 8'h00, 3'b000, 0, 11'h000, 0};
    tbl[2] = '{0, 8'h3C, 3'b100, 1, 11'h43C, 1};
    tbl[3] = '{0, 8'h55, 3'b000, 2, 11'h43C, 1};
    tbl[4] = '{1, 8'h00, 3'b000, 1, 11'h055, 1};
    tbl[5] = '{1, 8'h00, 3'b000, 0, 11'h000, 1};
    tbl[6] = '{1, 8'h00, 3'b000, 0, 11'h000, 1};
    tbl[7] = '{0, 8'hFF, 3'b011, 1, 11'h3FF, 2};
    tbl[8] = '{1, 8'h00, 3'b000, 0, 11'h000, 2};

    repeat (3) @(negedge clock);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_all();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].op == 0) send_frame(tbl[i].d, tbl[i].e, 1'b0, 1'b0);
      else                do_read();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(tbl[i].exp_errc));
    end

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 3'b000, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      do_read();
    end
    do_clear();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Full FIFO: simultaneous write+read, then overrun racing overrun_clr.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 3'b000, 1'b0, 1'b0);
    send_frame(8'h77, 3'b000, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_overrun", 32'(overrun), 32'd0);
    send_frame(8'h88, 3'b000, 1'b0, 1'b1);
    chk("set_beats_clr", 32'(overrun), 32'd1);
    last_head = '0;
    while (mq.size() > 0) begin
      last_head = rd_data;
      do_read();
    end
    chk("simul_last_entry", 32'(last_head), 32'h077);
    do_clear();

    // Threshold interrupt.
    @(negedge clock);
    rx_thresh = AW'(4);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h40 + i), 3'b000, 1'b0, 1'b0);
    chk("irq_below", 32'(rx_irq), 32'd0);
    send_frame(8'h43, 3'b000, 1'b0, 1'b0);
    chk("irq_at_thresh", 32'(rx_irq), 32'd1);
    do_read();
    chk("irq_after_read", 32'(rx_irq), 32'd0);
    repeat (3) do_read();

    // Write/read pairs, wrapping the pointers several times.
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      do_read();
    end

    // Random mix against the model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_frame(8'($urandom), 3'($urandom_range(0, 7)),
                               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        4, 5, 6: do_read();
        7: do_clear();
        default: begin
          @(negedge clock);
          rx_thresh = AW'($urandom_range(0, DEPTH - 1));
          @(negedge clock);
          check_all();
        end
      endcase
    end

    // Saturate err_count while keeping the FIFO level steady.
    while (mq.size() > 0) do_read();
    for (int i = 0; i < 260; i++) send_frame(8'(i), 3'b001, 1'b1, 1'b0);
    chk("err_saturated", 32'(err_count), 32'd255);

    // Asynchronous reset with five entries held.
    @(negedge clock);
    rx_thresh = AW'(2);
    for (int i = 0; i < 4; i++) send_frame(8'(8'h60 + i), 3'b010, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd5);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_empty", 32'(empty), 32'd1);
    chk("areset_full", 32'(full), 32'd0);
    chk("areset_rd_data", 32'(rd_data), 32'd0);
    chk("areset_irq", 32'(rx_irq), 32'd0);
    chk("areset_overrun", 32'(overrun), 32'd0);
    chk("areset_err_count", 32'(err_count), 32'd0);
    mq.delete(); ovr_m = 0; errc_m = 0;

    // rx_done already high at reset release, then held as a level: exactly one write.
    rx_data = 8'h5A; rx_error = 3'b000; rx_done = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clock);
      if (count == 1) seen = 1;
    end
    chk("release_write_seen", 32'(seen), 32'd1);
    mq.push_back(11'h05A);
    repeat (50) @(negedge clock);
    check_all();
    rx_done = 1'b0;
    repeat (4) @(negedge clock);
    check_all();
    do_read();
    do_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
